// File: rtl/sa4_tile_scheduler.sv
// Tile sequencer for a 4x4 systolic array: streams k_len operand rows from the
// buffer, skews the lanes into the array, waits for the array to drain and captures the result.
module sa4_tile_scheduler #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned C_WIDTH = 32,
  parameter int unsigned KW      = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 rd_en,
  output logic [KW-1:0]        rd_addr,
  input  logic [4*WIDTH-1:0]   act_rd_data,
  input  logic [4*WIDTH-1:0]   wgt_rd_data,
  output logic [4*WIDTH-1:0]   sa_activation,
  output logic [4*WIDTH-1:0]   sa_weight,
  output logic                 sa_control,
  input  logic [16*C_WIDTH-1:0] sa_c_out,
  output logic [16*C_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDone} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         klen_q, klen_d;
  logic [KW-1:0]         cnt_q, cnt_d;
  logic [2:0]            fcnt_q, fcnt_d;
  logic                  vld_q, vld_d;
  logic [16*C_WIDTH-1:0] result_q, result_d;

  logic [4*WIDTH-1:0]        act_in, wgt_in;
  logic [WIDTH-1:0]          act1_q, act1_d, wgt1_q, wgt1_d;
  logic [1:0][WIDTH-1:0]     act2_q, act2_d, wgt2_q, wgt2_d;
  logic [2:0][WIDTH-1:0]     act3_q, act3_d, wgt3_q, wgt3_d;

  always_comb begin
    state_d      = state_q;
    klen_d       = klen_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    result_d     = result_q;
    rd_en        = 1'b0;
    done         = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          klen_d  = k_len;
          cnt_d   = '0;
          state_d = (k_len == '0) ? StDone : StFeed;
        end
      end
      StFeed: begin
        rd_en = 1'b1;
        if (cnt_q == klen_q - KW'(1)) begin
          cnt_d   = '0;
          fcnt_d  = '0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StFlush: begin
        fcnt_d = fcnt_q + 3'd1;
        // Capture on the edge into DONE so result is already valid while done pulses.
        if (fcnt_q == 3'd7) begin
          result_d = sa_c_out;
          state_d  = StDone;
        end
      end
      StDone: begin
        done         = 1'b1;
        result_valid = (klen_q != '0);
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Returned data is only meaningful the cycle after a read; otherwise feed zeros.
  always_comb begin
    vld_d  = rd_en;
    act_in = vld_q ? act_rd_data : '0;
    wgt_in = vld_q ? wgt_rd_data : '0;
    act1_d = act_in[2*WIDTH +: WIDTH];
    wgt1_d = wgt_in[2*WIDTH +: WIDTH];
    act2_d = {act2_q[0], act_in[WIDTH +: WIDTH]};
    wgt2_d = {wgt2_q[0], wgt_in[WIDTH +: WIDTH]};
    act3_d = {act3_q[1:0], act_in[0 +: WIDTH]};
    wgt3_d = {wgt3_q[1:0], wgt_in[0 +: WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      klen_q   <= '0;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      vld_q    <= 1'b0;
      result_q <= '0;
      act1_q   <= '0;
      wgt1_q   <= '0;
      act2_q   <= '0;
      wgt2_q   <= '0;
      act3_q   <= '0;
      wgt3_q   <= '0;
    end else begin
      state_q  <= state_d;
      klen_q   <= klen_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      vld_q    <= vld_d;
      result_q <= result_d;
      act1_q   <= act1_d;
      wgt1_q   <= wgt1_d;
      act2_q   <= act2_d;
      wgt2_q   <= wgt2_d;
      act3_q   <= act3_d;
      wgt3_q   <= wgt3_d;
    end
  end

  assign rd_addr       = cnt_q;
  assign busy          = (state_q != StIdle);
  assign sa_control    = vld_q | (state_q == StFlush);
  assign sa_activation = {act_in[3*WIDTH +: WIDTH], act1_q, act2_q[1], act3_q[2]};
  assign sa_weight     = {wgt_in[3*WIDTH +: WIDTH], wgt1_q, wgt2_q[1], wgt3_q[2]};
  assign result        = result_q;

endmodule

// File: tb/tb_sa4_tile_scheduler.sv
// Directed bench for sa4_tile_scheduler: a registered operand buffer and a behavioural
// 4x4 output-stationary array surround the DUT; results are checked against dot products.
module tb_sa4_tile_scheduler;
  localparam int W  = 8;
  localparam int CW = 32;
  localparam int KW = 8;
  localparam int RW = 16 * CW;

  logic              clk = 1'b0;
  logic              rstn, start;
  logic [KW-1:0]     k_len;
  logic              rd_en;
  logic [KW-1:0]     rd_addr;
  logic [4*W-1:0]    act_rd_data, wgt_rd_data;
  logic [4*W-1:0]    sa_activation, sa_weight;
  logic              sa_control;
  logic [RW-1:0]     sa_c_out, result, exp_res, prev_res;
  logic              result_valid, busy, done;

  int tests = 0;
  int fails = 0;
  int lat;

  always #5 clk = ~clk;

  sa4_tile_scheduler #(.WIDTH(W), .C_WIDTH(CW), .KW(KW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .act_rd_data(act_rd_data), .wgt_rd_data(wgt_rd_data),
    .sa_activation(sa_activation), .sa_weight(sa_weight), .sa_control(sa_control),
    .sa_c_out(sa_c_out), .result(result), .result_valid(result_valid),
    .busy(busy), .done(done)
  );

  // Operand buffer: one-cycle read latency, garbage when not read.
  logic [4*W-1:0] act_mem [256];
  logic [4*W-1:0] wgt_mem [256];
  always @(posedge clk) begin
    if (rd_en) begin
      act_rd_data <= act_mem[rd_addr];
      wgt_rd_data <= wgt_mem[rd_addr];
    end else begin
      act_rd_data <= $urandom;
      wgt_rd_data <= $urandom;
    end
  end

  // Array: activations move right, weights move down, one hop per cycle.
  logic [W-1:0]  a_r [4][4];
  logic [W-1:0]  w_r [4][4];
  logic [CW-1:0] c_r [4][4];
  always @(posedge clk) begin : arr_model
    logic [W-1:0] ai, wi;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0) ai = sa_activation[(3-i)*W +: W];
        else        ai = a_r[i][j-1];
        if (i == 0) wi = sa_weight[(3-j)*W +: W];
        else        wi = w_r[i-1][j];
        if (!rstn) begin
          a_r[i][j] <= '0;
          w_r[i][j] <= '0;
          c_r[i][j] <= '0;
        end else begin
          a_r[i][j] <= ai;
          w_r[i][j] <= wi;
          c_r[i][j] <= sa_control ? c_r[i][j] + CW'(ai) * CW'(wi) : '0;
        end
      end
    end
  end

  always_comb begin
    sa_c_out = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        sa_c_out[(15-(i*4+j))*CW +: CW] = c_r[i][j];
  end

  // Activity monitors, sampled mid-cycle.
  int n_rden = 0, n_runs = 0, n_ctrl = 0, n_done = 0, n_rv = 0, n_aerr = 0;
  int s_rden, s_runs, s_ctrl, s_done, s_rv, s_aerr;
  logic          prev_rden = 1'b0;
  logic [KW-1:0] prev_addr = '0;
  logic [KW-1:0] max_addr = '0;
  always @(negedge clk) begin
    if (rd_en) begin
      n_rden++;
      if (!prev_rden) begin
        n_runs++;
        if (rd_addr != '0) n_aerr++;
      end else if (rd_addr != prev_addr + 8'd1) begin
        n_aerr++;
      end
      if (rd_addr > max_addr) max_addr = rd_addr;
      prev_addr = rd_addr;
    end
    prev_rden = rd_en;
    if (sa_control)   n_ctrl++;
    if (done)         n_done++;
    if (result_valid) n_rv++;
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_rden = n_rden; s_runs = n_runs; s_ctrl = n_ctrl;
    s_done = n_done; s_rv = n_rv;     s_aerr = n_aerr;
  endtask

  task automatic fill(input int k);
    for (int t = 0; t < k; t++) begin
      act_mem[t] = $urandom;
      wgt_mem[t] = $urandom;
    end
  endtask

  task automatic calc_exp(input int k);
    logic [CW-1:0] acc;
    exp_res = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int t = 0; t < k; t++)
          acc = acc + CW'(act_mem[t][(3-i)*W +: W]) * CW'(wgt_mem[t][(3-j)*W +: W]);
        exp_res[(15-(i*4+j))*CW +: CW] = acc;
      end
    end
  endtask

  // Drive start for one cycle; return cycles until done is seen (bounded).
  task automatic run_tile(input int k, output int l);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    l = 1;
    while (!done && l < 400) begin
      tick();
      l++;
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; k_len = '0;
    repeat (3) tick();
    chk("rst_busy",   RW'(busy), RW'(0));
    chk("rst_done",   RW'(done), RW'(0));
    chk("rst_rv",     RW'(result_valid), RW'(0));
    chk("rst_rd_en",  RW'(rd_en), RW'(0));
    chk("rst_ctrl",   RW'(sa_control), RW'(0));
    chk("rst_addr",   RW'(rd_addr), RW'(0));
    chk("rst_act",    RW'(sa_activation), RW'(0));
    chk("rst_wgt",    RW'(sa_weight), RW'(0));
    chk("rst_result", result, RW'(0));
    rstn = 1'b1;
    tick();

    // k=1, act {1,2,3,4}, weights all 1: PE(i,j) = i+1
    act_mem[0] = 32'h01020304;
    wgt_mem[0] = 32'h01010101;
    snap();
    run_tile(1, lat);
    chk_int("k1_latency", lat, 10);
    chk("k1_result", result, {{4{32'd1}}, {4{32'd2}}, {4{32'd3}}, {4{32'd4}}});
    chk("k1_rv", RW'(result_valid), RW'(1));
    chk("k1_busy_in_done", RW'(busy), RW'(1));
    tick();
    chk("k1_idle_busy", RW'(busy), RW'(0));
    chk_int("k1_done_cnt", n_done - s_done, 1);
    chk_int("k1_rv_cnt", n_rv - s_rv, 1);
    chk_int("k1_ctrl_cnt", n_ctrl - s_ctrl, 8);
    chk_int("k1_rden_cnt", n_rden - s_rden, 1);

    // k=4, identity weights: PE(i,j) = act row j, lane i
    act_mem[0] = 32'h0A0B0C0D; act_mem[1] = 32'h11121314;
    act_mem[2] = 32'h21222324; act_mem[3] = 32'h31323334;
    wgt_mem[0] = 32'h01000000; wgt_mem[1] = 32'h00010000;
    wgt_mem[2] = 32'h00000100; wgt_mem[3] = 32'h00000001;
    snap();
    run_tile(4, lat);
    chk_int("k4_latency", lat, 13);
    chk("k4_result", result, {32'h0A, 32'h11, 32'h21, 32'h31, 32'h0B, 32'h12, 32'h22, 32'h32,
                              32'h0C, 32'h13, 32'h23, 32'h33, 32'h0D, 32'h14, 32'h24, 32'h34});
    tick();
    chk_int("k4_ctrl_cnt", n_ctrl - s_ctrl, 11);
    chk_int("k4_rden_cnt", n_rden - s_rden, 4);
    chk_int("k4_addr_err", n_aerr - s_aerr, 0);

    // k=0: immediate done, no reads, no array activity, result held
    prev_res = result;
    snap();
    run_tile(0, lat);
    chk_int("k0_latency", lat, 1);
    chk("k0_rv", RW'(result_valid), RW'(0));
    tick();
    chk_int("k0_done_cnt", n_done - s_done, 1);
    chk_int("k0_rv_cnt", n_rv - s_rv, 0);
    chk_int("k0_rden_cnt", n_rden - s_rden, 0);
    chk_int("k0_ctrl_cnt", n_ctrl - s_ctrl, 0);
    chk("k0_result_held", result, prev_res);

    // start re-pulsed during FEED is ignored
    fill(6);
    calc_exp(6);
    snap();
    start = 1'b1; k_len = 8'd6;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; k_len = 8'd2;
    tick();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    chk_int("repulse_latency", lat, 15);
    chk("repulse_result", result, exp_res);
    tick();
    chk_int("repulse_done_cnt", n_done - s_done, 1);
    chk_int("repulse_rden_cnt", n_rden - s_rden, 6);

    // back-to-back start in the cycle after done
    fill(3);
    calc_exp(3);
    snap();
    run_tile(3, lat);
    chk_int("b2b_latency", lat, 12);
    chk("b2b_result", result, exp_res);
    tick();
    repeat (20) tick();
    chk_int("b2b_done_cnt", n_done - s_done, 1);

    // reset during FLUSH aborts the tile
    fill(5);
    snap();
    start = 1'b1; k_len = 8'd5;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("abort_busy_flush", RW'(busy), RW'(1));
    rstn = 1'b0;
    tick();
    chk("abort_busy",   RW'(busy), RW'(0));
    chk("abort_ctrl",   RW'(sa_control), RW'(0));
    chk("abort_rd_en",  RW'(rd_en), RW'(0));
    chk("abort_done",   RW'(done), RW'(0));
    chk("abort_act",    RW'(sa_activation), RW'(0));
    chk("abort_wgt",    RW'(sa_weight), RW'(0));
    chk("abort_result", result, RW'(0));
    rstn = 1'b1;
    repeat (20) tick();
    chk_int("abort_no_done", n_done - s_done, 0);
    chk_int("abort_no_rv", n_rv - s_rv, 0);
    fill(2);
    calc_exp(2);
    run_tile(2, lat);
    chk_int("post_abort_latency", lat, 11);
    chk("post_abort_result", result, exp_res);
    tick();

    // maximum length tile
    fill(255);
    calc_exp(255);
    snap();
    run_tile(255, lat);
    chk_int("k255_latency", lat, 264);
    chk("k255_result", result, exp_res);
    tick();
    chk_int("k255_rden_cnt", n_rden - s_rden, 255);
    chk_int("k255_runs", n_runs - s_runs, 1);
    chk_int("k255_addr_err", n_aerr - s_aerr, 0);
    chk("k255_max_addr", RW'(max_addr), RW'(254));
    chk_int("k255_ctrl_cnt", n_ctrl - s_ctrl, 262);
    repeat (3) tick();
    chk("k255_result_held", result, exp_res);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sa4_tile_scheduler.md
SA4_TILE_SCHEDULER -- requirements
Module: sa4_tile_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width per lane.
REQ-002 The block SHALL have parameter C_WIDTH, default 32: accumulator width per PE.
REQ-003 The block SHALL have parameter KW, default 8: width of k_len and rd_addr.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: tile start request, sampled only in IDLE.
REQ-007 The block SHALL have port k_len, input, KW bits: reduction length of the tile, sampled with start.
REQ-008 The block SHALL have port rd_en, output, 1 bit: operand buffer read enable.
REQ-009 The block SHALL have port rd_addr, output, KW bits: operand buffer read address.
REQ-010 The block SHALL have port act_rd_data, input, 4*WIDTH bits: activation row, valid 1 cycle after rd_en; lane 0 in MSBs.
REQ-011 The block SHALL have port wgt_rd_data, input, 4*WIDTH bits: weight column, same timing and lane order as act_rd_data.
REQ-012 The block SHALL have port sa_activation, output, 4*WIDTH bits: skewed activations to the 4x4 array.
REQ-013 The block SHALL have port sa_weight, output, 4*WIDTH bits: skewed weights to the array.
REQ-014 The block SHALL have port sa_control, output, 1 bit: array control; 1 = PEs accumulate, 0 = PEs clear/hold.
REQ-015 The block SHALL have port sa_c_out, input, 16*C_WIDTH bits: array accumulator outputs.
REQ-016 The block SHALL have port result, output, 16*C_WIDTH bits: captured tile result.
REQ-017 The block SHALL have port result_valid, output, 1 bit: result updated, 1-cycle pulse.
REQ-018 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-019 The block SHALL have port done, output, 1 bit: 1-cycle tile-complete pulse.

Function
REQ-020 States SHALL be IDLE, FEED, FLUSH, DONE; busy = (state != IDLE).
REQ-021 IDLE with start=1 and k_len>0 SHALL latch k_len and go to FEED; start with k_len=0 SHALL go to DONE without asserting sa_control or result_valid.
REQ-022 FEED SHALL last exactly k_len cycles with rd_en=1 and rd_addr = 0,1,...,k_len-1, one per cycle, then go to FLUSH.
REQ-023 Lane i (0..3) of act_rd_data and wgt_rd_data SHALL be delayed by i extra register stages before driving lane i of sa_activation/sa_weight (lane 0 = 0 extra stages, lane 3 = 3).
REQ-024 Skew registers SHALL load zero whenever returned read data is not valid (1 cycle after a cycle with rd_en=0).
REQ-025 FLUSH SHALL last exactly 8 cycles (1 read latency + 3 skew + 3 propagation + 1 PE register), then go to DONE.
REQ-026 sa_control SHALL be 1 from the first cycle returned data reaches sa_activation until the last FLUSH cycle, otherwise 0.
REQ-027 In DONE (1 cycle), result SHALL load sa_c_out, result_valid and done SHALL pulse 1, then state returns to IDLE.
REQ-028 start during busy SHALL be ignored; no queuing.
REQ-029 Total latency SHALL be start sample to done = k_len + 9 cycles for k_len>0.
REQ-030 k_len = 2^KW-1 SHALL run without address wrap; rd_addr SHALL never exceed k_len-1.
REQ-031 result SHALL hold its value outside DONE.

Reset
REQ-032 With rstn=0 at a clock edge: state=IDLE; rd_en, sa_control, busy, done and result_valid = 0; rd_addr, all skew registers, sa_activation, sa_weight and result = 0.
REQ-033 Reset asserted mid-tile SHALL abort the tile with no done pulse; the first start after release SHALL run a full tile.

Verification
REQ-034 k_len=1, act lanes {1,2,3,4}, weight lanes {1,1,1,1} -> done 10 cycles after start; result PE(i,j) = act_i*wgt_j.
REQ-035 k_len=4, identity weights -> each PE(i,j) equals the reference dot product; sa_control high for exactly k_len+7 cycles.
REQ-036 k_len=0 -> done 1 cycle after start; result_valid=0; rd_en and sa_control never 1.
REQ-037 start re-pulsed during FEED -> ignored, single done; back-to-back start in the cycle after done -> second tile starts normally.
REQ-038 rstn=0 during FLUSH -> next cycle all outputs 0, no done; a subsequent tile produces a correct result.
REQ-039 k_len=255 with random operands -> rd_addr 0..254 with no gap, result matches the model.
